// File: rtl/control_ventana_filtro.sv
// Sequencer for one ventana_pixeles pass over a frame with a 3x3 or 5x5 mask.
// Paces window consumption against the result FIFO and tracks window position.
module control_ventana_filtro #(
  parameter int ANCHO_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iniciar_proceso,
  input  logic [ANCHO_BITS-1:0] ancho_imagen,
  input  logic [ANCHO_BITS-1:0] alto_imagen,
  input  logic [2:0]            tamano_mascara,
  input  logic                  ventana_valida,
  input  logic                  salida_llena,
  output logic                  iniciar_ventana,
  output logic [2:0]            tamano_mascara_out,
  output logic [2:0]            cantidad_buffers,
  output logic                  siguiente_ventana,
  output logic                  escribir_resultado,
  output logic [ANCHO_BITS-1:0] columna,
  output logic [ANCHO_BITS-1:0] fila,
  output logic                  ocupado,
  output logic                  terminado,
  output logic                  error_config
);

  typedef enum logic [2:0] {
    REPOSO,
    ARRANQUE,
    ESPERA,
    CONSUMO,
    FIN
  } estado_t;

  estado_t estado;

  // Last valid window index per axis (window count minus one).
  logic [ANCHO_BITS-1:0] ultima_col;
  logic [ANCHO_BITS-1:0] ultima_fila;
  logic [ANCHO_BITS-1:0] mascara_ext;
  logic                  mascara_ok;
  logic                  config_ok;
  logic                  acepta;
  logic                  ultima;

  assign mascara_ext = {{(ANCHO_BITS-3){1'b0}}, tamano_mascara};
  assign mascara_ok  = (tamano_mascara == 3'd3) || (tamano_mascara == 3'd5);
  assign config_ok   = mascara_ok &&
                       (ancho_imagen >= mascara_ext) &&
                       (alto_imagen >= mascara_ext);

  assign acepta = (estado == ESPERA) && ventana_valida && !salida_llena;
  assign ultima = (columna == ultima_col) && (fila == ultima_fila);

  assign escribir_resultado = acepta;
  assign siguiente_ventana  = acepta;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado             <= REPOSO;
      iniciar_ventana    <= 1'b0;
      tamano_mascara_out <= '0;
      cantidad_buffers   <= '0;
      columna            <= '0;
      fila               <= '0;
      ocupado            <= 1'b0;
      terminado          <= 1'b0;
      error_config       <= 1'b0;
      ultima_col         <= '0;
      ultima_fila        <= '0;
    end else begin
      iniciar_ventana <= 1'b0;
      terminado       <= 1'b0;
      unique case (estado)
        REPOSO: begin
          if (iniciar_proceso) begin
            if (config_ok) begin
              error_config       <= 1'b0;
              tamano_mascara_out <= tamano_mascara;
              cantidad_buffers   <= tamano_mascara - 3'd1;
              ultima_col         <= ancho_imagen - mascara_ext;
              ultima_fila        <= alto_imagen - mascara_ext;
              columna            <= '0;
              fila               <= '0;
              iniciar_ventana    <= 1'b1;
              ocupado            <= 1'b1;
              estado             <= ARRANQUE;
            end else begin
              error_config <= 1'b1;
            end
          end
        end
        ARRANQUE: estado <= ESPERA;
        ESPERA: begin
          if (acepta) begin
            if (ultima) begin
              terminado <= 1'b1;
              estado    <= FIN;
            end else begin
              estado <= CONSUMO;
              if (columna == ultima_col) begin
                columna <= '0;
                fila    <= fila + 1'b1;
              end else begin
                columna <= columna + 1'b1;
              end
            end
          end
        end
        // Blanking cycle: the consumed window's valid may still be high.
        CONSUMO: estado <= ESPERA;
        FIN: begin
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_control_ventana_filtro.sv
// Bench for control_ventana_filtro: vector table, backpressure, reset and
// randomized frames checked against a window-list reference model.
module tb_control_ventana_filtro;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         iniciar_proceso;
  logic [W-1:0] ancho_imagen;
  logic [W-1:0] alto_imagen;
  logic [2:0]   tamano_mascara;
  logic         ventana_valida;
  logic         salida_llena;
  logic         iniciar_ventana;
  logic [2:0]   tamano_mascara_out;
  logic [2:0]   cantidad_buffers;
  logic         siguiente_ventana;
  logic         escribir_resultado;
  logic [W-1:0] columna;
  logic [W-1:0] fila;
  logic         ocupado;
  logic         terminado;
  logic         error_config;

  control_ventana_filtro #(.ANCHO_BITS(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .iniciar_proceso    (iniciar_proceso),
    .ancho_imagen       (ancho_imagen),
    .alto_imagen        (alto_imagen),
    .tamano_mascara     (tamano_mascara),
    .ventana_valida     (ventana_valida),
    .salida_llena       (salida_llena),
    .iniciar_ventana    (iniciar_ventana),
    .tamano_mascara_out (tamano_mascara_out),
    .cantidad_buffers   (cantidad_buffers),
    .siguiente_ventana  (siguiente_ventana),
    .escribir_resultado (escribir_resultado),
    .columna            (columna),
    .fila               (fila),
    .ocupado            (ocupado),
    .terminado          (terminado),
    .error_config       (error_config)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int last_mask  = 0;

  typedef struct {
    int ancho;
    int alto;
    int mascara;
    int modo;
    int err;
    int ventanas;
  } vec_t;

  vec_t tabla[11];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // modo 0: valid tied high; 1: random valid/full/start/config noise;
  // 2: full held 5 cycles during the third window.
  task automatic run_frame(input int a, input int h, input int m,
                           input int modo, input int abort_after,
                           output int nwin);
    int  exp_f[$];
    int  exp_c[$];
    bit  legal;
    bit  done;
    bit  prev_strobe;
    int  ivc, term, strobes, hold, cyc, last_cyc;
    legal = (m == 3 || m == 5) && a >= m && h >= m;
    if (legal)
      for (int r = 0; r < h - m + 1; r++)
        for (int c = 0; c < a - m + 1; c++) begin
          exp_f.push_back(r);
          exp_c.push_back(c);
        end
    done = 0; prev_strobe = 0;
    ivc = 0; term = 0; strobes = 0; hold = 0; cyc = 0; last_cyc = 0;
    @(posedge clk); #1;
    ancho_imagen    = W'(a);
    alto_imagen     = W'(h);
    tamano_mascara  = 3'(m);
    iniciar_proceso = 1'b1;
    ventana_valida  = 1'b0;
    salida_llena    = 1'b0;
    @(negedge clk);
    check("idle_before_start", int'(iniciar_ventana), 0);
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (modo == 1) begin
        iniciar_proceso = 1'($urandom_range(0, 1));
        ancho_imagen    = W'($urandom_range(0, 20));
        alto_imagen     = W'($urandom_range(0, 20));
        tamano_mascara  = 3'($urandom_range(0, 7));
        ventana_valida  = 1'($urandom_range(0, 1));
        salida_llena    = 1'($urandom_range(0, 2) == 0);
      end else begin
        iniciar_proceso = 1'b0;
        ventana_valida  = 1'b1;
        salida_llena    = (modo == 2 && strobes == 2 && hold < 5);
        if (salida_llena) hold++;
      end
      @(negedge clk);
      check("sig_matches_wr", int'(siguiente_ventana),
            int'(escribir_resultado));
      if (!legal) check("ocupado_idle", int'(ocupado), 0);
      if (iniciar_ventana) begin
        ivc++;
        check("start_latency", cyc, 1);
        check("mask_out", int'(tamano_mascara_out), m);
        check("buffers", int'(cantidad_buffers), m - 1);
        check("ocupado_start", int'(ocupado), 1);
      end
      if (modo == 2 && salida_llena) begin
        check("bp_no_strobe", int'(escribir_resultado), 0);
        check("bp_col", int'(columna), 2);
        check("bp_fila", int'(fila), 0);
      end
      if (escribir_resultado) begin
        check("strobe_gated", int'(ventana_valida && !salida_llena), 1);
        check("strobe_spacing", int'(prev_strobe), 0);
        check("ocupado_run", int'(ocupado), 1);
        if (modo == 0) begin
          if (strobes == 0) check("first_strobe", cyc, 2);
          else check("strobe_gap", cyc - last_cyc, 2);
        end
        if (exp_f.size() == 0) begin
          check("extra_window", 1, 0);
        end else begin
          check("fila", int'(fila), exp_f.pop_front());
          check("columna", int'(columna), exp_c.pop_front());
        end
        strobes++;
        last_cyc = cyc;
        if (abort_after != 0 && strobes == abort_after) done = 1;
      end
      if (terminado) begin
        term++;
        check("term_after_last", exp_f.size(), 0);
        check("term_follows_strobe", int'(prev_strobe), 1);
        check("ocupado_fin", int'(ocupado), 1);
        done = 1;
      end
      prev_strobe = escribir_resultado;
      if (!legal && cyc >= 8) done = 1;
    end
    check("frame_bounded", int'(done), 1);
    if (legal) begin
      check("start_pulses", ivc, 1);
      check("err_cleared", int'(error_config), 0);
      last_mask = m;
      if (abort_after == 0) begin
        check("term_pulses", term, 1);
        @(posedge clk); #1;
        iniciar_proceso = 1'b0;
        @(negedge clk);
        check("ocupado_after", int'(ocupado), 0);
        check("term_one_cycle", int'(terminado), 0);
        check("buffers_held", int'(cantidad_buffers), m - 1);
      end
    end else begin
      check("no_start_illegal", ivc, 0);
      check("err_set", int'(error_config), 1);
      check("buffers_kept", int'(cantidad_buffers),
            last_mask == 0 ? 0 : last_mask - 1);
    end
    nwin = strobes;
  endtask

  initial begin
    int n;
    tabla[0]  = '{5, 4, 3, 0, 0, 6};
    tabla[1]  = '{4, 5, 4, 0, 1, 0};
    tabla[2]  = '{5, 4, 3, 0, 0, 6};
    tabla[3]  = '{2, 7, 3, 0, 1, 0};
    tabla[4]  = '{5, 5, 5, 0, 0, 1};
    tabla[5]  = '{7, 2, 5, 0, 1, 0};
    tabla[6]  = '{6, 5, 7, 0, 1, 0};
    tabla[7]  = '{3, 3, 3, 1, 0, 1};
    tabla[8]  = '{10, 6, 5, 1, 0, 12};
    tabla[9]  = '{3, 10, 3, 1, 0, 8};
    tabla[10] = '{8, 3, 3, 1, 0, 6};

    reset = 1'b1;
    iniciar_proceso = 1'b0;
    ancho_imagen = '0;
    alto_imagen = '0;
    tamano_mascara = '0;
    ventana_valida = 1'b0;
    salida_llena = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iniciar", int'(iniciar_ventana), 0);
    check("rst_mask", int'(tamano_mascara_out), 0);
    check("rst_buffers", int'(cantidad_buffers), 0);
    check("rst_col", int'(columna), 0);
    check("rst_fila", int'(fila), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_term", int'(terminado), 0);
    check("rst_err", int'(error_config), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tabla[i]) begin
      run_frame(tabla[i].ancho, tabla[i].alto, tabla[i].mascara,
                tabla[i].modo, 0, n);
      check("vec_windows", n, tabla[i].ventanas);
      check("vec_err", int'(error_config), tabla[i].err);
    end

    run_frame(5, 4, 3, 2, 0, n);
    check("bp_windows", n, 6);

    run_frame(5, 4, 3, 0, 3, n);
    check("pre_reset_windows", n, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_iniciar", int'(iniciar_ventana), 0);
    check("mid_rst_wr", int'(escribir_resultado), 0);
    check("mid_rst_sig", int'(siguiente_ventana), 0);
    check("mid_rst_col", int'(columna), 0);
    check("mid_rst_fila", int'(fila), 0);
    check("mid_rst_ocupado", int'(ocupado), 0);
    check("mid_rst_buffers", int'(cantidad_buffers), 0);
    check("mid_rst_mask", int'(tamano_mascara_out), 0);
    check("mid_rst_err", int'(error_config), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_rst_no_term", int'(terminado), 0);
    end
    last_mask = 0;
    run_frame(5, 4, 3, 0, 0, n);
    check("restart_windows", n, 6);

    for (int k = 0; k < 6; k++) begin
      int a, h, m;
      m = ($urandom_range(0, 1) == 0) ? 3 : 5;
      a = $urandom_range(m, 14);
      h = $urandom_range(m, 10);
      run_frame(a, h, m, 1, 0, n);
      check("rand_windows", n, (a - m + 1) * (h - m + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
